// File: rtl/mux_operand_skid.sv
// Two-entry skid buffer delivering registered {sel, a, b, c} operand beats to the
// mux datapath, with a saturating count of beats handed downstream.
module mux_operand_skid #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sel,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sel,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic [WIDTH-1:0]     out_c,
  output logic [CNT_WIDTH-1:0] beat_count
);

  localparam int PW = 3 * WIDTH + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        out_q, out_d;
  logic [PW-1:0]        skid_q, skid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic [PW-1:0] in_payload;
  logic          in_xfer;
  logic          out_xfer;

  assign in_payload = {in_sel, in_a, in_b, in_c};
  assign in_xfer    = in_valid && in_ready_q;
  assign out_xfer   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          out_d   = in_payload;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          out_d = in_payload;
        end else if (in_xfer) begin
          skid_d  = in_payload;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so any input attempt is ignored
        if (out_xfer) begin
          out_d   = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (out_xfer && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Handshake outputs come from their own flops, decoded from the next state
  assign in_ready_d  = (state_d != FULL);
  assign out_valid_d = (state_d != EMPTY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign {out_sel, out_a, out_b, out_c} = out_q;
  assign beat_count = cnt_q;

endmodule
